// File: rtl/sfifo_flex_if.sv
// sfifo_flex_if: handshake bundle between a producer/consumer pair and sfifo_flex.
//
// Signals:
//   winc, wdata           write request and its data (producer -> FIFO)
//   rinc                  read request / pop (consumer -> FIFO)
//   rdata                 read data (FIFO -> consumer)
//   wfull, rempty         occupancy is DEPTH / 0
//   almost_full           count >= AF_LEVEL
//   almost_empty          count <= AE_LEVEL
//   count                 occupancy, 0..DEPTH
//   overflow, underflow   one-cycle pulses after a rejected write / read
//
// Modports:
//   master  the user side: drives requests, observes status and data
//   slave   the FIFO side
interface sfifo_flex_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             winc;
    logic [WIDTH-1:0] wdata;
    logic             rinc;
    logic [WIDTH-1:0] rdata;
    logic             wfull;
    logic             rempty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output winc,
        output wdata,
        output rinc,
        input  rdata,
        input  wfull,
        input  rempty,
        input  almost_full,
        input  almost_empty,
        input  count,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  winc,
        input  wdata,
        input  rinc,
        output rdata,
        output wfull,
        output rempty,
        output almost_full,
        output almost_empty,
        output count,
        output overflow,
        output underflow
    );
endinterface

// File: rtl/sfifo_flex.sv
// sfifo_flex: single-clock FIFO with internal storage, selectable read mode
// (registered read or first-word-fall-through), occupancy count, programmable
// almost-full / almost-empty thresholds and overflow / underflow error pulses.
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset; discards queued data
//   bus    sfifo_flex_if.slave: winc/wdata/rinc in; rdata, wfull, rempty,
//          almost_full, almost_empty, count, overflow, underflow out
//
// Parameters:
//   WIDTH     data width (>= 1)
//   DEPTH     entries, power of two, >= 2
//   FWFT      0 = rdata registered on pop; 1 = rdata shows the head word
//   AF_LEVEL  almost_full when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  almost_empty when count <= AE_LEVEL (0..DEPTH-1)
module sfifo_flex #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned FWFT     = 0,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    sfifo_flex_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [CW-1:0] AF_THRESH = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_THRESH = CW'(AE_LEVEL);
    localparam logic [CW-1:0] PTR_ONE   = CW'(1);

    // Pointers carry one extra wrap bit so that full and empty stay distinct
    // across any number of wraps.
    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic          full, empty;
    logic          wr_en, rd_en;
    logic [CW-1:0] occupancy;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    always_comb begin
        wr_addr   = wr_ptr_q[AW-1:0];
        rd_addr   = rd_ptr_q[AW-1:0];
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_addr == rd_addr);
        occupancy = wr_ptr_q - rd_ptr_q;

        // Acceptance uses flags from before the edge, so a full FIFO still
        // pops on a simultaneous request and an empty one still pushes.
        wr_en = bus.winc && !full;
        rd_en = bus.rinc && !empty;

        wr_ptr_d = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = rd_en ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        overflow_d  = bus.winc && full;
        underflow_d = bus.rinc && empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= bus.wdata;
        end
    end

    generate
        if (FWFT == 0) begin : g_std_read
            logic [WIDTH-1:0] rdata_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (rd_en) begin
                    rdata_q <= mem_q[rd_addr];
                end
            end

            assign bus.rdata = rdata_q;
        end else begin : g_fwft_read
            // Head word is shown directly; content while empty is stale.
            assign bus.rdata = mem_q[rd_addr];
        end
    endgenerate

    assign bus.wfull        = full;
    assign bus.rempty       = empty;
    assign bus.count        = occupancy;
    assign bus.almost_full  = (occupancy >= AF_THRESH);
    assign bus.almost_empty = (occupancy <= AE_THRESH);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sfifo_flex.sv
// tb_sfifo_flex: directed bench for sfifo_flex. Two instances share clk and
// rst_n: u_std (FWFT=0) and u_fw (FWFT=1), both WIDTH=8, DEPTH=16.
module tb_sfifo_flex;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sfifo_flex_if #(.WIDTH(8), .DEPTH(16)) bus_s ();
    sfifo_flex_if #(.WIDTH(8), .DEPTH(16)) bus_f ();

    sfifo_flex #(.WIDTH(8), .DEPTH(16), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) u_std (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    sfifo_flex #(.WIDTH(8), .DEPTH(16), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)) u_fw (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after a rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_s.winc = 1'b0; bus_s.rinc = 1'b0; bus_s.wdata = 8'h00;
        bus_f.winc = 1'b0; bus_f.rinc = 1'b0; bus_f.wdata = 8'h00;
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();
        total++; if (bus_s.rempty !== 1'b1) begin bad++; $display("FAIL reset_rempty got=%b exp=1", bus_s.rempty); end
        total++; if (bus_s.wfull !== 1'b0) begin bad++; $display("FAIL reset_wfull got=%b exp=0", bus_s.wfull); end
        total++; if (bus_s.count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus_s.count); end
        total++; if (bus_s.almost_empty !== 1'b1) begin bad++; $display("FAIL reset_ae got=%b exp=1", bus_s.almost_empty); end
        total++; if (bus_s.almost_full !== 1'b0) begin bad++; $display("FAIL reset_af got=%b exp=0", bus_s.almost_full); end
        total++; if (bus_s.rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h exp=00", bus_s.rdata); end
        total++; if ({bus_s.overflow, bus_s.underflow} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", {bus_s.overflow, bus_s.underflow}); end
        total++; if (bus_f.rempty !== 1'b1) begin bad++; $display("FAIL reset_fw_rempty got=%b exp=1", bus_f.rempty); end
        // Empty read: rejected, one underflow pulse, rdata untouched.
        bus_s.rinc = 1'b1;
        cycle();
        bus_s.rinc = 1'b0;
        total++; if (bus_s.underflow !== 1'b1) begin bad++; $display("FAIL empty_rd_underflow got=%b exp=1", bus_s.underflow); end
        total++; if (bus_s.rdata !== 8'h00) begin bad++; $display("FAIL empty_rd_rdata got=%h exp=00", bus_s.rdata); end
        total++; if (bus_s.count !== 5'd0) begin bad++; $display("FAIL empty_rd_count got=%0d exp=0", bus_s.count); end
        cycle();
        total++; if (bus_s.underflow !== 1'b0) begin bad++; $display("FAIL empty_rd_pulse_len got=%b exp=0", bus_s.underflow); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            bus_s.winc = 1'b1;
            bus_s.wdata = 8'(i);
            cycle();
            total++; if (bus_s.count !== 5'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, bus_s.count, i + 1); end
            total++; if (bus_s.almost_full !== ((i + 1) >= 14)) begin bad++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, bus_s.almost_full, (i + 1) >= 14); end
            total++; if (bus_s.wfull !== ((i + 1) == 16)) begin bad++; $display("FAIL fill_wfull[%0d] got=%b exp=%b", i, bus_s.wfull, (i + 1) == 16); end
            total++; if (bus_s.rempty !== 1'b0) begin bad++; $display("FAIL fill_rempty[%0d] got=%b exp=0", i, bus_s.rempty); end
        end
        bus_s.wdata = 8'hFF;
        cycle();
        bus_s.winc = 1'b0;
        total++; if (bus_s.overflow !== 1'b1) begin bad++; $display("FAIL overflow_pulse got=%b exp=1", bus_s.overflow); end
        total++; if (bus_s.count !== 5'd16) begin bad++; $display("FAIL overflow_count got=%0d exp=16", bus_s.count); end
        cycle();
        total++; if (bus_s.overflow !== 1'b0) begin bad++; $display("FAIL overflow_pulse_len got=%b exp=0", bus_s.overflow); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            bus_s.rinc = 1'b1;
            cycle();
            total++; if (bus_s.rdata !== 8'(i)) begin bad++; $display("FAIL drain_rdata[%0d] got=%h exp=%h", i, bus_s.rdata, 8'(i)); end
            total++; if (bus_s.count !== 5'(15 - i)) begin bad++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, bus_s.count, 15 - i); end
            total++; if (bus_s.almost_empty !== ((15 - i) <= 2)) begin bad++; $display("FAIL drain_ae[%0d] got=%b exp=%b", i, bus_s.almost_empty, (15 - i) <= 2); end
        end
        bus_s.rinc = 1'b0;
        total++; if (bus_s.rempty !== 1'b1) begin bad++; $display("FAIL drain_rempty got=%b exp=1", bus_s.rempty); end
        total++; if (bus_s.underflow !== 1'b0) begin bad++; $display("FAIL drain_underflow got=%b exp=0", bus_s.underflow); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) begin
            bus_s.winc = 1'b1;
            bus_s.wdata = 8'(8'h40 + i);
            cycle();
        end
        // Full: pop accepted, push rejected.
        bus_s.wdata = 8'hEE;
        bus_s.rinc = 1'b1;
        cycle();
        bus_s.winc = 1'b0;
        bus_s.rinc = 1'b0;
        total++; if (bus_s.overflow !== 1'b1) begin bad++; $display("FAIL full_both_overflow got=%b exp=1", bus_s.overflow); end
        total++; if (bus_s.rdata !== 8'h40) begin bad++; $display("FAIL full_both_rdata got=%h exp=40", bus_s.rdata); end
        total++; if (bus_s.count !== 5'd15) begin bad++; $display("FAIL full_both_count got=%0d exp=15", bus_s.count); end
        for (int i = 1; i < 16; i++) begin
            bus_s.rinc = 1'b1;
            cycle();
            total++; if (bus_s.rdata !== 8'(8'h40 + i)) begin bad++; $display("FAIL full_both_drain[%0d] got=%h exp=%h", i, bus_s.rdata, 8'(8'h40 + i)); end
        end
        total++; if (bus_s.rempty !== 1'b1) begin bad++; $display("FAIL full_both_empty got=%b exp=1", bus_s.rempty); end
        // Empty: push accepted, pop rejected.
        bus_s.winc = 1'b1;
        bus_s.wdata = 8'h77;
        cycle();
        bus_s.winc = 1'b0;
        bus_s.rinc = 1'b0;
        total++; if (bus_s.count !== 5'd1) begin bad++; $display("FAIL empty_both_count got=%0d exp=1", bus_s.count); end
        total++; if (bus_s.underflow !== 1'b1) begin bad++; $display("FAIL empty_both_underflow got=%b exp=1", bus_s.underflow); end
        total++; if (bus_s.rdata !== 8'h4F) begin bad++; $display("FAIL empty_both_rdata_hold got=%h exp=4f", bus_s.rdata); end
        bus_s.rinc = 1'b1;
        cycle();
        bus_s.rinc = 1'b0;
        total++; if (bus_s.rdata !== 8'h77) begin bad++; $display("FAIL empty_both_pop got=%h exp=77", bus_s.rdata); end
        total++; if (bus_s.rempty !== 1'b1) begin bad++; $display("FAIL empty_both_rempty got=%b exp=1", bus_s.rempty); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] wr_seq;
        logic [7:0] rd_seq;
        wr_seq = 8'h20;
        rd_seq = 8'h20;
        for (int i = 0; i < 8; i++) begin
            bus_s.winc = 1'b1;
            bus_s.wdata = wr_seq;
            wr_seq++;
            cycle();
        end
        for (int i = 0; i < 40; i++) begin
            bus_s.winc = 1'b1;
            bus_s.rinc = 1'b1;
            bus_s.wdata = wr_seq;
            wr_seq++;
            cycle();
            total++; if (bus_s.count !== 5'd8) begin bad++; $display("FAIL b2b_count[%0d] got=%0d exp=8", i, bus_s.count); end
            total++; if (bus_s.rdata !== rd_seq) begin bad++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", i, bus_s.rdata, rd_seq); end
            rd_seq++;
        end
        bus_s.winc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_s.rinc = 1'b1;
            cycle();
            total++; if (bus_s.rdata !== rd_seq) begin bad++; $display("FAIL b2b_drain[%0d] got=%h exp=%h", i, bus_s.rdata, rd_seq); end
            rd_seq++;
        end
        bus_s.rinc = 1'b0;
        total++; if (bus_s.rempty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b exp=1", bus_s.rempty); end
    endtask

    task automatic test_fwft();
        bus_f.winc = 1'b1;
        bus_f.wdata = 8'hA5;
        cycle();
        bus_f.winc = 1'b0;
        total++; if (bus_f.rempty !== 1'b0) begin bad++; $display("FAIL fwft_rempty got=%b exp=0", bus_f.rempty); end
        total++; if (bus_f.rdata !== 8'hA5) begin bad++; $display("FAIL fwft_first_word got=%h exp=a5", bus_f.rdata); end
        bus_f.winc = 1'b1;
        bus_f.wdata = 8'h3C;
        cycle();
        bus_f.winc = 1'b0;
        total++; if (bus_f.rdata !== 8'hA5) begin bad++; $display("FAIL fwft_head_hold got=%h exp=a5", bus_f.rdata); end
        total++; if (bus_f.count !== 5'd2) begin bad++; $display("FAIL fwft_count2 got=%0d exp=2", bus_f.count); end
        bus_f.rinc = 1'b1;
        cycle();
        bus_f.rinc = 1'b0;
        total++; if (bus_f.rdata !== 8'h3C) begin bad++; $display("FAIL fwft_pop got=%h exp=3c", bus_f.rdata); end
        total++; if (bus_f.count !== 5'd1) begin bad++; $display("FAIL fwft_count1 got=%0d exp=1", bus_f.count); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) begin
            bus_s.winc = 1'b1;
            bus_s.wdata = 8'(8'h90 + i);
            cycle();
        end
        bus_s.winc = 1'b0;
        total++; if (bus_s.count !== 5'd9) begin bad++; $display("FAIL mid_pre_count got=%0d exp=9", bus_s.count); end
        // Reset between edges must act without a clock edge.
        rst_n = 1'b0;
        #2;
        total++; if (bus_s.count !== 5'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", bus_s.count); end
        total++; if (bus_s.rempty !== 1'b1) begin bad++; $display("FAIL mid_rempty got=%b exp=1", bus_s.rempty); end
        total++; if (bus_s.almost_empty !== 1'b1) begin bad++; $display("FAIL mid_ae got=%b exp=1", bus_s.almost_empty); end
        total++; if (bus_s.rdata !== 8'h00) begin bad++; $display("FAIL mid_rdata got=%h exp=00", bus_s.rdata); end
        total++; if (bus_f.rempty !== 1'b1) begin bad++; $display("FAIL mid_fw_rempty got=%b exp=1", bus_f.rempty); end
        #3;
        rst_n = 1'b1;
        cycle();
        bus_s.winc = 1'b1;
        bus_s.wdata = 8'hC1;
        cycle();
        bus_s.wdata = 8'hC2;
        cycle();
        bus_s.winc = 1'b0;
        bus_s.rinc = 1'b1;
        cycle();
        bus_s.rinc = 1'b0;
        total++; if (bus_s.rdata !== 8'hC1) begin bad++; $display("FAIL mid_restart_rdata got=%h exp=c1", bus_s.rdata); end
        total++; if (bus_s.count !== 5'd1) begin bad++; $display("FAIL mid_restart_count got=%0d exp=1", bus_s.count); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_back_to_back();
        test_fwft();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
